// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 host receiver: FSM state encoding,
// error cause codes and frame geometry.
package ps2_pkg;

    // Start + 8 data + parity + stop.
    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [3:0] {
        ST_RX_IDLE   = 4'd0,
        ST_RX_SHIFT  = 4'd1,
        ST_RX_PARITY = 4'd2,
        ST_RX_STOP   = 4'd3
    } rx_state_e;

    typedef enum logic [1:0] {
        ERR_TIMEOUT = 2'd0,
        ERR_START   = 2'd1,
        ERR_PARITY  = 2'd2,
        ERR_STOP    = 2'd3
    } rx_err_e;

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioning: 2-FF synchronisers on PS2C/PS2D, optional PS2C
// glitch filter (compiled in with PS2_RX_GLITCH_FILTER_EN) and a PS2C
// falling-edge strobe. All line registers reset to 1 (idle bus level) so
// no false edge follows reset.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic qzt_clk,
    input  logic reset,
    input  logic PS2C,
    input  logic PS2D,
    output logic ps2c_lvl,
    output logic ps2d_lvl,
    output logic fall
);

    logic [1:0] c_sync;
    logic [1:0] d_sync;
    logic       c_prev;

    // Two-stage synchronisers for both asynchronous lines.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            c_sync <= 2'b11;
            d_sync <= 2'b11;
        end else begin
            c_sync <= {c_sync[0], PS2C};
            d_sync <= {d_sync[0], PS2D};
        end
    end

`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);

    logic [FW-1:0] f_cnt;
    logic          c_filt;

    // Follow the synchronised clock only after FILTER_LEN identical samples.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            c_filt <= 1'b1;
            f_cnt  <= '0;
        end else if (c_sync[1] == c_filt) begin
            f_cnt <= '0;
        end else if (f_cnt == FW'(FILTER_LEN - 1)) begin
            c_filt <= c_sync[1];
            f_cnt  <= '0;
        end else begin
            f_cnt <= f_cnt + FW'(1);
        end
    end

    assign ps2c_lvl = c_filt;
`else
    // Filter length only matters when the filter is built in.
    logic unused_filter_len;
    assign unused_filter_len = (FILTER_LEN != 0);
    assign ps2c_lvl = c_sync[1];
`endif

    // Previous clock level for the falling-edge strobe.
    always_ff @(posedge qzt_clk) begin
        if (reset) c_prev <= 1'b1;
        else       c_prev <= ps2c_lvl;
    end

    assign fall     = c_prev & ~ps2c_lvl;
    assign ps2d_lvl = d_sync[1];

endmodule

// File: rtl/ps2_receive.sv
// Host-side PS/2 device-to-host frame receiver. Deserialises start, 8 data
// bits LSB first, odd parity and stop; emits a one-cycle valid or err pulse
// per frame. Optional PS2C glitch filter: PS2_RX_GLITCH_FILTER_EN.
module ps2_receive
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TIMEOUT_US = 2000,
    parameter int FILTER_LEN = 8
) (
    input  logic       qzt_clk,
    input  logic       reset,
    input  logic       PS2C,
    input  logic       PS2D,
    input  logic       enable,
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy,
    output logic [3:0] status
);

    localparam int DATA_BITS   = PS2_FRAME_BITS - 3;
    localparam int TIMEOUT_CYC = (CLK_HZ / 1_000_000) * TIMEOUT_US;
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);

    rx_state_e   state, state_nxt;
    logic        fall, ps2d, ps2c_lvl_unused;
    logic [7:0]  sr;
    logic [2:0]  bit_cnt;
    logic        par;
    logic [TW-1:0] to_cnt;
    logic        timeout;
    logic        valid_nxt, err_nxt;
    logic [1:0]  code_nxt;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_line (
        .qzt_clk  (qzt_clk),
        .reset    (reset),
        .PS2C     (PS2C),
        .PS2D     (PS2D),
        .ps2c_lvl (ps2c_lvl_unused),
        .ps2d_lvl (ps2d),
        .fall     (fall)
    );

    assign timeout = (state != ST_RX_IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));

    // State register.
    always_ff @(posedge qzt_clk) begin
        if (reset) state <= ST_RX_IDLE;
        else       state <= state_nxt;
    end

    // Next state: a clock edge always beats a same-cycle timeout; disable wins over both.
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = ST_RX_IDLE;
        end else begin
            case (state)
                ST_RX_IDLE:   if (fall && !ps2d) state_nxt = ST_RX_SHIFT;
                ST_RX_SHIFT:  if (fall) begin
                                  if (bit_cnt == 3'(DATA_BITS - 1)) state_nxt = ST_RX_PARITY;
                              end else if (timeout) state_nxt = ST_RX_IDLE;
                ST_RX_PARITY: if (fall) state_nxt = ST_RX_STOP;
                              else if (timeout) state_nxt = ST_RX_IDLE;
                ST_RX_STOP:   if (fall || timeout) state_nxt = ST_RX_IDLE;
                default:      state_nxt = ST_RX_IDLE;
            endcase
        end
    end

    // Frame outcome: decides the valid/err pulse and error cause for this cycle.
    always_comb begin
        valid_nxt = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = err_code;
        if (enable) begin
            case (state)
                ST_RX_IDLE: if (fall && ps2d) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_START;
                end
                ST_RX_SHIFT, ST_RX_PARITY: if (!fall && timeout) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_TIMEOUT;
                end
                ST_RX_STOP: if (fall) begin
                    if (!ps2d) begin
                        err_nxt  = 1'b1;
                        code_nxt = ERR_STOP;
                    end else if (!(^sr ^ par)) begin
                        err_nxt  = 1'b1;
                        code_nxt = ERR_PARITY;
                    end else begin
                        valid_nxt = 1'b1;
                    end
                end else if (timeout) begin
                    err_nxt  = 1'b1;
                    code_nxt = ERR_TIMEOUT;
                end
                default: ;
            endcase
        end
    end

    // Datapath: shift register, bit/timeout counters and registered pulses.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            data     <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
            err_code <= '0;
            sr       <= '0;
            bit_cnt  <= '0;
            par      <= 1'b0;
            to_cnt   <= '0;
        end else begin
            valid    <= valid_nxt;
            err      <= err_nxt;
            err_code <= code_nxt;
            if (valid_nxt) data <= sr;
            if (state == ST_RX_IDLE) begin
                bit_cnt <= '0;
                to_cnt  <= '0;
            end else begin
                to_cnt <= fall ? '0 : to_cnt + TW'(1);
                if (enable && fall) begin
                    if (state == ST_RX_SHIFT) begin
                        sr      <= {ps2d, sr[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    if (state == ST_RX_PARITY) par <= ps2d;
                end
            end
        end
    end

    assign busy   = (state != ST_RX_IDLE);
    assign status = state;

endmodule

// File: tb/tb_ps2_receive.sv
// Self-checking bench for ps2_receive: directed scenarios plus randomized
// frames scored against a frame-level reference model.
module tb_ps2_receive;
    import ps2_pkg::*;

    localparam int CLK_HZ   = 1_000_000;
    localparam int TOUT_US  = 2000;
    localparam int FLT      = 8;
    localparam int TOUT_CYC = (CLK_HZ / 1_000_000) * TOUT_US;
`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int LAT = 3 + FLT;
`else
    localparam int LAT = 3;
`endif

    logic       qzt_clk = 1'b0, reset = 1'b1, PS2C = 1'b1, PS2D = 1'b1, enable = 1'b0;
    logic [7:0] data;
    logic       valid, err, busy;
    logic [1:0] err_code;
    logic [3:0] status;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, n_valid = 0, n_err = 0, n_both = 0, pulse_cyc = 0, fall_cyc = 0;
    logic [7:0] exp_data = 8'h00;

    ps2_receive #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TOUT_US), .FILTER_LEN(FLT)) dut (
        .qzt_clk(qzt_clk), .reset(reset), .PS2C(PS2C), .PS2D(PS2D), .enable(enable),
        .data(data), .valid(valid), .err(err), .err_code(err_code),
        .busy(busy), .status(status)
    );

    always #5 qzt_clk = ~qzt_clk;

    always @(posedge qzt_clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge qzt_clk) begin
        if (valid) begin n_valid <= n_valid + 1; pulse_cyc <= cyc; end
        if (err)   begin n_err <= n_err + 1; pulse_cyc <= cyc; end
        if (valid && err) n_both <= n_both + 1;
    end

    function automatic logic [10:0] mk_frame(input logic start, input logic [7:0] d,
                                             input logic par, input logic stop);
        return {stop, par, d, start};
    endfunction

    // Reference: -1 means a good frame, otherwise the expected error cause.
    function automatic int ref_code(input logic start, input logic [7:0] d,
                                    input logic par, input logic stop);
        if (start) return 1;
        if (!stop) return 3;
        if ((($countones(d) + int'(par)) % 2) == 0) return 2;
        return -1;
    endfunction

    task automatic drive_bits(input logic [10:0] bits, input int n, input int half,
                              input int glitch_at);
        for (int i = 0; i < n; i++) begin
            @(negedge qzt_clk);
            PS2D = bits[i];
            if (i == glitch_at) begin
                repeat (half / 2) @(negedge qzt_clk);
                PS2C = 1'b0;
                repeat (3) @(negedge qzt_clk);
                PS2C = 1'b1;
                repeat (half - half / 2 - 3) @(negedge qzt_clk);
            end else begin
                repeat (half) @(negedge qzt_clk);
            end
            PS2C = 1'b0;
            fall_cyc = cyc;
            repeat (half) @(negedge qzt_clk);
            PS2C = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(negedge qzt_clk);
        reset = 1'b0;
        @(negedge qzt_clk);
        n_cmp++; if (data !== 8'h00)   begin n_bad++; $display("FAIL reset.data: got %0h want 0", data); end
        n_cmp++; if (valid !== 1'b0)   begin n_bad++; $display("FAIL reset.valid: got %b want 0", valid); end
        n_cmp++; if (err !== 1'b0)     begin n_bad++; $display("FAIL reset.err: got %b want 0", err); end
        n_cmp++; if (err_code !== 2'd0) begin n_bad++; $display("FAIL reset.err_code: got %0d want 0", err_code); end
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset.busy: got %b want 0", busy); end
        n_cmp++; if (status !== 4'd0)  begin n_bad++; $display("FAIL reset.status: got %0d want 0", status); end
        enable = 1'b1;
    endtask

    task automatic test_good_fa();
        int v0 = n_valid, e0 = n_err;
        drive_bits(mk_frame(1'b0, 8'hFA, 1'b1, 1'b1), 11, 40, -1);
        repeat (2) @(negedge qzt_clk);
        exp_data = 8'hFA;
        n_cmp++; if (n_valid - v0 !== 1) begin n_bad++; $display("FAIL good_fa.valid_cycles: got %0d want 1", n_valid - v0); end
        n_cmp++; if (n_err - e0 !== 0)   begin n_bad++; $display("FAIL good_fa.err_cycles: got %0d want 0", n_err - e0); end
        n_cmp++; if (data !== exp_data)  begin n_bad++; $display("FAIL good_fa.data: got %0h want %0h", data, exp_data); end
        n_cmp++; if (pulse_cyc - fall_cyc !== LAT) begin n_bad++; $display("FAIL good_fa.latency: got %0d want %0d", pulse_cyc - fall_cyc, LAT); end
        n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL good_fa.busy: got %b want 0", busy); end
    endtask

    task automatic test_parity_err();
        int v0 = n_valid, e0 = n_err;
        drive_bits(mk_frame(1'b0, 8'h00, 1'b0, 1'b1), 11, 24, -1);
        repeat (2) @(negedge qzt_clk);
        n_cmp++; if (n_err - e0 !== 1)   begin n_bad++; $display("FAIL parity.err_cycles: got %0d want 1", n_err - e0); end
        n_cmp++; if (n_valid - v0 !== 0) begin n_bad++; $display("FAIL parity.valid_cycles: got %0d want 0", n_valid - v0); end
        n_cmp++; if (err_code !== 2'd2)  begin n_bad++; $display("FAIL parity.err_code: got %0d want 2", err_code); end
        n_cmp++; if (data !== exp_data)  begin n_bad++; $display("FAIL parity.data: got %0h want %0h", data, exp_data); end
    endtask

    task automatic test_start_err();
        int e0 = n_err;
        logic [10:0] one_bit = 11'h001;
        drive_bits(one_bit, 1, 20, -1);
        repeat (2) @(negedge qzt_clk);
        n_cmp++; if (n_err - e0 !== 1)  begin n_bad++; $display("FAIL start.err_cycles: got %0d want 1", n_err - e0); end
        n_cmp++; if (err_code !== 2'd1) begin n_bad++; $display("FAIL start.err_code: got %0d want 1", err_code); end
        n_cmp++; if (status !== 4'd0)   begin n_bad++; $display("FAIL start.status: got %0d want 0", status); end
    endtask

    task automatic test_stop_err();
        int v0 = n_valid, e0 = n_err;
        drive_bits(mk_frame(1'b0, 8'h81, 1'b1, 1'b0), 11, 20, -1);
        repeat (2) @(negedge qzt_clk);
        n_cmp++; if (n_err - e0 !== 1)   begin n_bad++; $display("FAIL stop.err_cycles: got %0d want 1", n_err - e0); end
        n_cmp++; if (n_valid - v0 !== 0) begin n_bad++; $display("FAIL stop.valid_cycles: got %0d want 0", n_valid - v0); end
        n_cmp++; if (err_code !== 2'd3)  begin n_bad++; $display("FAIL stop.err_code: got %0d want 3", err_code); end
    endtask

    task automatic test_timeout();
        int v0, e0 = n_err, lat;
        drive_bits(mk_frame(1'b0, 8'h5C, 1'b1, 1'b1), 5, 20, -1);
        for (int k = 0; k < TOUT_CYC + 200 && n_err == e0; k++) @(negedge qzt_clk);
        @(negedge qzt_clk);
        lat = pulse_cyc - fall_cyc;
        n_cmp++; if (n_err - e0 !== 1)  begin n_bad++; $display("FAIL timeout.err_cycles: got %0d want 1", n_err - e0); end
        n_cmp++; if (err_code !== 2'd0) begin n_bad++; $display("FAIL timeout.err_code: got %0d want 0", err_code); end
        n_cmp++; if (lat < TOUT_CYC + LAT - 1 || lat > TOUT_CYC + LAT + 1)
            begin n_bad++; $display("FAIL timeout.latency: got %0d want %0d+-1", lat, TOUT_CYC + LAT); end
        v0 = n_valid;
        drive_bits(mk_frame(1'b0, 8'hAA, 1'b1, 1'b1), 11, 20, -1);
        repeat (2) @(negedge qzt_clk);
        exp_data = 8'hAA;
        n_cmp++; if (n_valid - v0 !== 1) begin n_bad++; $display("FAIL timeout.after_valid: got %0d want 1", n_valid - v0); end
        n_cmp++; if (data !== exp_data)  begin n_bad++; $display("FAIL timeout.after_data: got %0h want %0h", data, exp_data); end
    endtask

    task automatic test_enable_drop();
        int v0 = n_valid, e0 = n_err;
        drive_bits(mk_frame(1'b0, 8'h37, 1'b0, 1'b1), 6, 20, -1);
        n_cmp++; if (status !== 4'd1) begin n_bad++; $display("FAIL en_drop.status_mid: got %0d want 1", status); end
        enable = 1'b0;
        @(negedge qzt_clk);
        n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL en_drop.busy: got %b want 0", busy); end
        repeat (30) @(negedge qzt_clk);
        n_cmp++; if (n_valid - v0 + n_err - e0 !== 0) begin n_bad++; $display("FAIL en_drop.pulses: got %0d want 0", n_valid - v0 + n_err - e0); end
        n_cmp++; if (data !== exp_data) begin n_bad++; $display("FAIL en_drop.data: got %0h want %0h", data, exp_data); end
        enable = 1'b1;
    endtask

    task automatic test_enable_at_stop();
        int v0 = n_valid, e0 = n_err;
        drive_bits(mk_frame(1'b0, 8'h3C, 1'b1, 1'b1), 10, 20, -1);
        @(negedge qzt_clk);
        PS2D = 1'b1;
        repeat (20) @(negedge qzt_clk);
        PS2C = 1'b0;
        fall_cyc = cyc;
        repeat (LAT - 1) @(negedge qzt_clk);
        enable = 1'b0;
        repeat (21 - LAT) @(negedge qzt_clk);
        PS2C = 1'b1;
        repeat (4) @(negedge qzt_clk);
        n_cmp++; if (n_valid - v0 + n_err - e0 !== 0) begin n_bad++; $display("FAIL en_stop.pulses: got %0d want 0", n_valid - v0 + n_err - e0); end
        n_cmp++; if (data !== exp_data) begin n_bad++; $display("FAIL en_stop.data: got %0h want %0h", data, exp_data); end
        n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL en_stop.busy: got %b want 0", busy); end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        int v0 = n_valid, e0 = n_err;
        drive_bits(mk_frame(1'b0, 8'h99, 1'b1, 1'b1), 4, 20, -1);
        reset = 1'b1;
        @(negedge qzt_clk);
        reset = 1'b0;
        repeat (3) @(negedge qzt_clk);
        exp_data = 8'h00;
        n_cmp++; if (status !== 4'd0) begin n_bad++; $display("FAIL reset_mid.status: got %0d want 0", status); end
        n_cmp++; if (n_valid - v0 + n_err - e0 !== 0) begin n_bad++; $display("FAIL reset_mid.pulses: got %0d want 0", n_valid - v0 + n_err - e0); end
        n_cmp++; if (data !== exp_data) begin n_bad++; $display("FAIL reset_mid.data: got %0h want %0h", data, exp_data); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 16; f++) begin
            logic [7:0] d = 8'($urandom);
            int r = $urandom_range(0, 5);
            logic par = ~(^d) ^ (r == 0);
            logic stop = (r != 1);
            int half = $urandom_range(16, 40);
            int code = ref_code(1'b0, d, par, stop);
            int v0 = n_valid, e0 = n_err;
            drive_bits(mk_frame(1'b0, d, par, stop), 11, half, -1);
            repeat (2) @(negedge qzt_clk);
            if (code < 0) exp_data = d;
            n_cmp++; if (n_valid - v0 !== (code < 0 ? 1 : 0)) begin n_bad++; $display("FAIL rand%0d.valid_cycles: got %0d d=%0h", f, n_valid - v0, d); end
            n_cmp++; if (n_err - e0 !== (code < 0 ? 0 : 1))   begin n_bad++; $display("FAIL rand%0d.err_cycles: got %0d d=%0h", f, n_err - e0, d); end
            if (code >= 0) begin
                n_cmp++; if (int'(err_code) !== code) begin n_bad++; $display("FAIL rand%0d.err_code: got %0d want %0d", f, err_code, code); end
            end
            n_cmp++; if (data !== exp_data) begin n_bad++; $display("FAIL rand%0d.data: got %0h want %0h", f, data, exp_data); end
        end
    endtask

`ifdef PS2_RX_GLITCH_FILTER_EN
    task automatic test_glitch();
        int v0 = n_valid, e0 = n_err;
        drive_bits(mk_frame(1'b0, 8'hC5, 1'b1, 1'b1), 11, 20, 4);
        repeat (2) @(negedge qzt_clk);
        exp_data = 8'hC5;
        n_cmp++; if (n_valid - v0 !== 1) begin n_bad++; $display("FAIL glitch.valid_cycles: got %0d want 1", n_valid - v0); end
        n_cmp++; if (n_err - e0 !== 0)   begin n_bad++; $display("FAIL glitch.err_cycles: got %0d want 0", n_err - e0); end
        n_cmp++; if (data !== exp_data)  begin n_bad++; $display("FAIL glitch.data: got %0h want %0h", data, exp_data); end
    endtask
`endif

    initial begin
        test_reset();
        test_good_fa();
        test_parity_err();
        test_start_err();
        test_stop_err();
        test_timeout();
        test_enable_drop();
        test_enable_at_stop();
        test_reset_mid();
        test_random();
`ifdef PS2_RX_GLITCH_FILTER_EN
        test_glitch();
`endif
        n_cmp++; if (n_both !== 0) begin n_bad++; $display("FAIL exclusive.valid_and_err: got %0d cycles want 0", n_both); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
